// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// No logic of its own; pure types, constants and elaboration-time functions.
// Backpressure is handled by the users of this package, not here.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold 0..QW/UNROLL.
  function automatic int cnt_width(input int qw, input int unroll);
    return $clog2(qw / unroll + 1);
  endfunction

  localparam int DEF_QW     = 16;
  localparam int DEF_UNROLL = 1;
  localparam int DEF_CNT_W  = cnt_width(DEF_QW, DEF_UNROLL);

  // Only power-of-two unroll factors up to 8 are supported.
  function automatic bit unroll_legal(input int unroll);
    return (unroll == 1) || (unroll == 2) || (unroll == 4) || (unroll == 8);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for the restoring divider.
// No latency; wires only.
// master drives operands and out_ready; slave (the divider) drives the rest.
interface seq_restoring_divider_if #(
  parameter int DW = 16,
  parameter int YW = 32,
  parameter int QW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_q;
  logic [YW-1:0] out_r;
  logic          out_sat;
  logic          out_dbz;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_sat, out_dbz
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_q, out_r, out_sat, out_dbz
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract Y if it fits.
// Purely combinational, zero cycles.
// No handshake; chained UNROLL times inside the divider.
module div_step #(
  parameter int YW = 32
) (
  input  logic [YW-1:0] p_in,
  input  logic          bit_in,
  input  logic [YW-1:0] y,
  output logic [YW-1:0] p_out,
  output logic          q_bit
);
  logic [YW:0] t;

  // Trial subtraction on the YW+1 bit partial remainder; restore when it goes negative.
  always_comb begin
    t     = {p_in, bit_in};
    q_bit = (t >= {1'b0, y});
    p_out = q_bit ? YW'(t - {1'b0, y}) : t[YW-1:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// Fixed-point divider Q = floor((X<<FRAC)/Y), UNROLL quotient bits per clock.
// Latency QW/UNROLL cycles on the normal path, result in the next cycle on dbz/sat.
// Single op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW     = 16,
  parameter int YW     = 32,
  parameter int QW     = 16,
  parameter int FRAC   = 16,
  parameter int UNROLL = 1
) (
  input logic                   clk,
  input logic                   rst,
  seq_restoring_divider_if.slave bus
);
  localparam int NW    = DW + FRAC;
  localparam int CW    = (NW > YW) ? NW : YW;
  localparam int STEPS = QW / UNROLL;
  localparam int CNT_W = cnt_width(QW, UNROLL);

  if (!unroll_legal(UNROLL) || (QW % UNROLL != 0) || (DW + FRAC < QW)) begin : g_bad_cfg
    $error("seq_restoring_divider: illegal UNROLL/QW/DW/FRAC combination");
  end

  state_t              state, state_nxt;
  logic [YW-1:0]       p;
  logic [QW-1:0]       s;
  logic [QW-1:0]       q;
  logic [YW-1:0]       y_reg;
  logic [CNT_W-1:0]    cnt;
  logic [QW-1:0]       q_res;
  logic [YW-1:0]       r_res;
  logic                sat_flag;
  logic                dbz_flag;

  logic [NW-1:0]       n_full;
  logic [CW-1:0]       h_ext;
  logic [CW-1:0]       y_ext;
  logic                y_zero;
  logic                h_ge;
  logic                last_step;
  logic [QW-1:0]       q_next;

  logic [YW-1:0]       p_chain [UNROLL+1];
  logic [UNROLL-1:0]   q_bits;

  assign n_full    = NW'(bus.in_x) << FRAC;
  assign h_ext     = CW'(n_full >> QW);
  assign y_ext     = CW'(bus.in_y);
  assign y_zero    = (bus.in_y == '0);
  // H >= Y means the quotient cannot fit in QW bits.
  assign h_ge      = (h_ext >= y_ext);
  assign last_step = (cnt == CNT_W'(STEPS - 1));

  // Step 0 consumes the current MSB of s and yields the most significant new quotient bit.
  assign p_chain[0] = p;
  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    div_step #(.YW(YW)) u_step (
      .p_in  (p_chain[k]),
      .bit_in(s[QW-1-k]),
      .y     (y_reg),
      .p_out (p_chain[k+1]),
      .q_bit (q_bits[UNROLL-1-k])
    );
  end

  assign q_next = (q << UNROLL) | QW'(q_bits);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: error cases skip RUN and go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (y_zero || h_ge) ? DONE : RUN;
      RUN:     if (last_step)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, UNROLL steps per RUN cycle, result latch on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      p        <= '0;
      s        <= '0;
      q        <= '0;
      y_reg    <= '0;
      cnt      <= '0;
      q_res    <= '0;
      r_res    <= '0;
      sat_flag <= 1'b0;
      dbz_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (y_zero) begin
              q_res    <= '1;
              r_res    <= '0;
              sat_flag <= 1'b0;
              dbz_flag <= 1'b1;
            end else if (h_ge) begin
              q_res    <= '1;
              r_res    <= '0;
              sat_flag <= 1'b1;
              dbz_flag <= 1'b0;
            end else begin
              p     <= YW'(h_ext);
              s     <= n_full[QW-1:0];
              q     <= '0;
              cnt   <= '0;
              y_reg <= bus.in_y;
            end
          end
        end
        RUN: begin
          p   <= p_chain[UNROLL];
          s   <= s << UNROLL;
          q   <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            q_res    <= q_next;
            r_res    <= p_chain[UNROLL];
            sat_flag <= 1'b0;
            dbz_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_q     = q_res;
  assign bus.out_r     = r_res;
  assign bus.out_sat   = sat_flag;
  assign bus.out_dbz   = dbz_flag;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomised bench for seq_restoring_divider.
// Latency is counted in rising edges after the accept edge (0 = valid right after accept).
// Exercises backpressure by holding out_ready low in DONE.
module tb_seq_restoring_divider;
  localparam int DW     = 16;
  localparam int YW     = 32;
  localparam int QW     = 16;
  localparam int FRAC   = 16;
  localparam int UNROLL = 1;
  localparam int STEPS  = QW / UNROLL;
  localparam logic [63:0] QMAX = (64'd1 << QW) - 64'd1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.DW(DW), .YW(YW), .QW(QW)) bus ();

  seq_restoring_divider #(
    .DW(DW), .YW(YW), .QW(QW), .FRAC(FRAC), .UNROLL(UNROLL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Waits for in_ready, presents one operand pair for a single accept edge, then
  // counts edges until out_valid is seen.
  task automatic run_op(input logic [DW-1:0] x, input logic [YW-1:0] y, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_wait", bus.out_valid, 1);
  endtask

  task automatic check_vec(input string tag, input logic [DW-1:0] x, input logic [YW-1:0] y,
                           input logic [QW-1:0] eq, input logic [YW-1:0] er,
                           input logic esat, input logic edbz);
    int lat;
    bus.out_ready = 1'b1;
    run_op(x, y, lat);
    chk({tag, "_lat"}, 64'(lat), (esat || edbz) ? 64'd0 : 64'(STEPS));
    chk({tag, "_q"},   bus.out_q, eq);
    chk({tag, "_r"},   bus.out_r, er);
    chk({tag, "_sat"}, bus.out_sat, esat);
    chk({tag, "_dbz"}, bus.out_dbz, edbz);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int guard;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_q",         bus.out_q, 0);
    chk("rst_r",         bus.out_r, 0);
    chk("rst_sat",       bus.out_sat, 0);
    chk("rst_dbz",       bus.out_dbz, 0);
    rst = 1'b0;

    // Directed vectors (N = X<<16).
    check_vec("one_by_3",   16'h0001, 32'h0000_0003, 16'h5555, 32'h0000_0001, 1'b0, 1'b0);
    check_vec("ff_by_100",  16'h00FF, 32'h0000_0100, 16'hFF00, 32'h0000_0000, 1'b0, 1'b0);
    check_vec("sat_3_3",    16'h0003, 32'h0000_0003, 16'hFFFF, 32'h0000_0000, 1'b1, 1'b0);
    check_vec("dbz_5",      16'h0005, 32'h0000_0000, 16'hFFFF, 32'h0000_0000, 1'b0, 1'b1);
    check_vec("big_y",      16'hFFFF, 32'hFFFF_FFFF, 16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);
    check_vec("zero_x",     16'h0000, 32'h0000_0007, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    check_vec("two_by_3",   16'h0002, 32'h0000_0003, 16'hAAAA, 32'h0000_0002, 1'b0, 1'b0);
    check_vec("max_no_sat", 16'hFFFF, 32'h0001_0000, 16'hFFFF, 32'h0000_0000, 1'b0, 1'b0);
    check_vec("sat_1_1",    16'h0001, 32'h0000_0001, 16'hFFFF, 32'h0000_0000, 1'b1, 1'b0);
    check_vec("dbz_0",      16'h0000, 32'h0000_0000, 16'hFFFF, 32'h0000_0000, 1'b0, 1'b1);

    // Backpressure: hold the result for 5 cycles with a new op queued behind it.
    bus.out_ready = 1'b0;
    run_op(16'h0001, 32'h0000_0003, lat);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h00FF;
    bus.in_y     = 32'h0000_0100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_q", bus.out_q, 16'h5555);
      chk("bp_r", bus.out_r, 32'h1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", bus.out_valid, 0);
    chk("bp_rel_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    chk("bp_queued_accept", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_queued_lat", 64'(lat), 64'(STEPS));
    chk("bp_queued_q", bus.out_q, 16'hFF00);
    @(posedge clk); #1;

    // Reset in the middle of RUN after 7 steps.
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h0001;
    bus.in_y     = 32'h0000_0003;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready",  bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_q",         bus.out_q, 0);
    chk("mid_rst_r",         bus.out_r, 0);
    chk("mid_rst_flags",     {bus.out_sat, bus.out_dbz}, 0);
    guard = 0;
    while (!bus.out_valid && guard < 3) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("mid_rst_no_stale_valid", bus.out_valid, 0);
    check_vec("post_rst", 16'h0001, 32'h0000_0003, 16'h5555, 32'h0000_0001, 1'b0, 1'b0);

    // Random operands against an arithmetic reference with random out_ready stalls.
    for (int it = 0; it < 1000; it++) begin
      logic [DW-1:0] rx;
      logic [YW-1:0] ry;
      logic [63:0]   n, quo, eq, er;
      logic          esat, edbz;
      int            hold;
      rx = DW'($urandom);
      ry = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) ry = '0;
      n = 64'(rx) << FRAC;
      if (ry == '0) begin
        eq = QMAX; er = 0; esat = 1'b0; edbz = 1'b1;
      end else begin
        quo = n / 64'(ry);
        if (quo > QMAX) begin
          eq = QMAX; er = 0; esat = 1'b1; edbz = 1'b0;
        end else begin
          eq = quo; er = n % 64'(ry); esat = 1'b0; edbz = 1'b0;
        end
      end
      bus.out_ready = 1'b1;
      run_op(rx, ry, lat);
      bus.out_ready = 1'b0;
      chk("rand_lat", 64'(lat), (esat || edbz) ? 64'd0 : 64'(STEPS));
      chk("rand_q",   bus.out_q, eq);
      chk("rand_r",   bus.out_r, er);
      chk("rand_flags", {bus.out_sat, bus.out_dbz}, {esat, edbz});
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("rand_hold_q", bus.out_q, eq);
        chk("rand_hold_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
